// File: rtl/flow_light_ctrl_pkg.sv
// Shared definitions for the flowing-lights run/speed controller:
// FSM state encoding and the chaser speed-code limits.
package flow_light_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10
    } fsm_state_t;

    localparam logic [1:0] FREQ_MIN = 2'b00;
    localparam logic [1:0] FREQ_MAX = 2'b11;

endpackage

// File: rtl/flow_light_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle strobe on each accepted press (a release gives no strobe).
module flow_light_ctrl_btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          db_reg;
    logic [CW-1:0] cnt_reg;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after it has differed from the debounced
    // level for DEBOUNCE_CYC consecutive cycles; strobe on an accepted press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_reg    <= 1'b0;
            cnt_reg   <= '0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            if (sync2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                db_reg    <= sync2_reg;
                cnt_reg   <= '0;
                btn_pulse <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flow_light_ctrl.sv
// Run/speed controller for the LED chaser. A debounced button starts/stops
// the chaser; in MANUAL each press steps the speed, in AUTO the speed steps
// on a dwell timer. Every speed change issues a one-cycle chaser restart.
module flow_light_ctrl
    import flow_light_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int DWELL_CYC    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       auto_en,
    output logic       run,
    output logic [1:0] freq_set,
    output logic       lights_rst,
    output logic       btn_pulse,
    output logic [1:0] state
);

    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYC - 1);

    fsm_state_t    state_reg;
    logic [DW-1:0] dwell_reg;
    logic          auto_en_reg;

    flow_light_ctrl_btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_pulse (btn_pulse)
    );

    assign state = state_reg;

    // Mode FSM with registered outputs; a press outranks an auto_en change,
    // which outranks a dwell expiry, so a press never coincides with a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            dwell_reg   <= '0;
            auto_en_reg <= 1'b0;
            run         <= 1'b0;
            freq_set    <= FREQ_MIN;
            lights_rst  <= 1'b0;
        end else begin
            auto_en_reg <= auto_en;
            lights_rst  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    dwell_reg <= '0;
                    if (btn_pulse) begin
                        state_reg  <= auto_en ? ST_AUTO : ST_MANUAL;
                        run        <= 1'b1;
                        freq_set   <= FREQ_MIN;
                        lights_rst <= 1'b1;
                    end
                end
                ST_MANUAL: begin
                    dwell_reg <= '0;
                    if (btn_pulse) begin
                        if (freq_set == FREQ_MAX) begin
                            state_reg <= ST_IDLE;
                            run       <= 1'b0;
                            freq_set  <= FREQ_MIN;
                        end else begin
                            freq_set   <= freq_set + 2'd1;
                            lights_rst <= 1'b1;
                        end
                    end else if (auto_en && !auto_en_reg) begin
                        state_reg <= ST_AUTO;
                    end
                end
                ST_AUTO: begin
                    if (btn_pulse) begin
                        state_reg <= ST_IDLE;
                        run       <= 1'b0;
                        freq_set  <= FREQ_MIN;
                        dwell_reg <= '0;
                    end else if (!auto_en) begin
                        state_reg <= ST_MANUAL;
                        dwell_reg <= '0;
                    end else if (dwell_reg == DWELL_MAX) begin
                        freq_set   <= freq_set + 2'd1;
                        dwell_reg  <= '0;
                        lights_rst <= 1'b1;
                    end else begin
                        dwell_reg <= dwell_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    run       <= 1'b0;
                    freq_set  <= FREQ_MIN;
                    dwell_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flow_light_ctrl.sv
// Directed bench for flow_light_ctrl (DEBOUNCE_CYC=4, DWELL_CYC=16).
module tb_flow_light_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       auto_en;
    logic       run;
    logic [1:0] freq_set;
    logic       lights_rst;
    logic       btn_pulse;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    flow_light_ctrl #(
        .DEBOUNCE_CYC (4),
        .DWELL_CYC    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .auto_en    (auto_en),
        .run        (run),
        .freq_set   (freq_set),
        .lights_rst (lights_rst),
        .btn_pulse  (btn_pulse),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clean press: pulse appears 6 edges after raising btn_raw, FSM reacts
    // on the following edge. Returns just after that FSM edge.
    task automatic press();
        btn_raw = 1'b1;
        repeat (6) tick();
        check("press_pulse", {7'd0, btn_pulse}, 8'd1);
        btn_raw = 1'b0;
        tick();
        check("press_pulse_end", {7'd0, btn_pulse}, 8'd0);
    endtask

    initial begin
        rst     = 1'b0;
        btn_raw = 1'b0;
        auto_en = 1'b0;

        // Reset state before any clock edge
        #1;
        check("rst_run", {7'd0, run}, 8'd0);
        check("rst_freq", {6'd0, freq_set}, 8'd0);
        check("rst_lrst", {7'd0, lights_rst}, 8'd0);
        check("rst_pulse", {7'd0, btn_pulse}, 8'd0);
        check("rst_state", {6'd0, state}, 8'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Glitch of 3 cycles is rejected
        btn_raw = 1'b1;
        repeat (3) tick();
        btn_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_pulse", {7'd0, btn_pulse}, 8'd0);
        end
        check("glitch_state", {6'd0, state}, 8'd0);

        // Manual mode: five presses
        auto_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            press();
            check("man_state", {6'd0, state}, (i < 4) ? 8'd1 : 8'd0);
            check("man_run", {7'd0, run}, (i < 4) ? 8'd1 : 8'd0);
            check("man_freq", {6'd0, freq_set}, (i < 4) ? 8'(i) : 8'd0);
            check("man_lrst", {7'd0, lights_rst}, (i < 4) ? 8'd1 : 8'd0);
            tick();
            check("man_lrst_end", {7'd0, lights_rst}, 8'd0);
            repeat (7) tick();
        end

        // Auto mode: steps every 16 cycles, wrapping 11 -> 00
        auto_en = 1'b1;
        press();
        check("auto_state", {6'd0, state}, 8'd2);
        check("auto_run", {7'd0, run}, 8'd1);
        check("auto_freq0", {6'd0, freq_set}, 8'd0);
        check("auto_lrst0", {7'd0, lights_rst}, 8'd1);
        for (int c = 1; c <= 96; c++) begin
            tick();
            check("auto_freq", {6'd0, freq_set}, 8'((c / 16) % 4));
            check("auto_lrst", {7'd0, lights_rst}, (c % 16 == 0) ? 8'd1 : 8'd0);
            check("auto_pulse", {7'd0, btn_pulse}, 8'd0);
        end

        // Drop auto_en at freq=10: back to MANUAL, speed held
        auto_en = 1'b0;
        tick();
        check("a2m_state", {6'd0, state}, 8'd1);
        check("a2m_freq", {6'd0, freq_set}, 8'd2);
        check("a2m_lrst", {7'd0, lights_rst}, 8'd0);
        check("a2m_run", {7'd0, run}, 8'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("a2m_hold_freq", {6'd0, freq_set}, 8'd2);
            check("a2m_hold_lrst", {7'd0, lights_rst}, 8'd0);
        end
        press();
        check("a2m_press_freq", {6'd0, freq_set}, 8'd3);
        check("a2m_press_lrst", {7'd0, lights_rst}, 8'd1);
        check("a2m_press_state", {6'd0, state}, 8'd1);
        repeat (8) tick();

        // Re-enter AUTO at freq=11, then press landing on dwell==15
        auto_en = 1'b1;
        tick();
        check("m2a_state", {6'd0, state}, 8'd2);
        check("m2a_freq", {6'd0, freq_set}, 8'd3);
        repeat (9) tick();
        btn_raw = 1'b1;
        repeat (6) tick();
        check("coin_pulse", {7'd0, btn_pulse}, 8'd1);
        check("coin_freq_pre", {6'd0, freq_set}, 8'd3);
        btn_raw = 1'b0;
        tick();
        check("coin_state", {6'd0, state}, 8'd0);
        check("coin_run", {7'd0, run}, 8'd0);
        check("coin_freq", {6'd0, freq_set}, 8'd0);
        check("coin_lrst", {7'd0, lights_rst}, 8'd0);
        tick();
        check("coin_lrst_after", {7'd0, lights_rst}, 8'd0);
        check("coin_freq_after", {6'd0, freq_set}, 8'd0);
        repeat (8) tick();

        // Asynchronous reset mid-run, between edges
        auto_en = 1'b0;
        press();
        repeat (8) tick();
        press();
        check("pre_rst_freq", {6'd0, freq_set}, 8'd1);
        check("pre_rst_lrst", {7'd0, lights_rst}, 8'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_run", {7'd0, run}, 8'd0);
        check("arst_freq", {6'd0, freq_set}, 8'd0);
        check("arst_lrst", {7'd0, lights_rst}, 8'd0);
        check("arst_state", {6'd0, state}, 8'd0);
        check("arst_pulse", {7'd0, btn_pulse}, 8'd0);
        tick();
        check("arst_hold_state", {6'd0, state}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
